eth_frame_loop_arbiter: RTL and testbench

ETH_FRAME_LOOP_ARBITER -- requirements
Module: eth_frame_loop_arbiter

---
 rtl/eth_frame_loop_arbiter_if.sv | 30 +++
 rtl/eth_frame_loop_arbiter.sv | 111 +++++++++++
 tb/tb_eth_frame_loop_arbiter.sv | 284 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/eth_frame_loop_arbiter_if.sv
// eth_frame_loop_arbiter_if: two source byte streams and the merged output stream of the frame arbiter
interface eth_frame_loop_arbiter_if;
  logic [7:0] s0_axis_tdata;
  logic [9:0] s0_axis_tuser;
  logic       s0_axis_tlast;
  logic       s0_axis_tvalid;
  logic       s0_axis_tready;
  logic [7:0] s1_axis_tdata;
  logic [9:0] s1_axis_tuser;
  logic       s1_axis_tlast;
  logic       s1_axis_tvalid;
  logic       s1_axis_tready;
  logic [7:0] m_axis_tdata;
  logic [9:0] m_axis_tuser;
  logic       m_axis_tlast;
  logic       m_axis_tvalid;
  logic       m_axis_tid;
  modport slave (
    input  s0_axis_tdata, s0_axis_tuser, s0_axis_tlast, s0_axis_tvalid,
    input  s1_axis_tdata, s1_axis_tuser, s1_axis_tlast, s1_axis_tvalid,
    output s0_axis_tready, s1_axis_tready,
    output m_axis_tdata, m_axis_tuser, m_axis_tlast, m_axis_tvalid, m_axis_tid
  );
  modport master (
    output s0_axis_tdata, s0_axis_tuser, s0_axis_tlast, s0_axis_tvalid,
    output s1_axis_tdata, s1_axis_tuser, s1_axis_tlast, s1_axis_tvalid,
    input  s0_axis_tready, s1_axis_tready,
    input  m_axis_tdata, m_axis_tuser, m_axis_tlast, m_axis_tvalid, m_axis_tid
  );
endinterface

// File: rtl/eth_frame_loop_arbiter.sv
// eth_frame_loop_arbiter: frame-granular round-robin merge of two byte streams with stall abort and inter-frame gap
module eth_frame_loop_arbiter #(
  parameter logic [15:0] TIMEOUT = 16'd255,
  parameter logic [7:0]  IFG     = 8'd0
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [1:0]              enable,
  eth_frame_loop_arbiter_if.slave bus,
  output logic                    busy,
  output logic [31:0]             frame_count0,
  output logic [31:0]             frame_count1,
  output logic [15:0]             abort_count
);
  typedef enum logic [2:0] {ST_IDLE, ST_SEND, ST_ABORT, ST_DRAIN, ST_GAP} state_t;
  state_t      state;
  state_t      end_state;
  logic        grant;
  logic        last_grant;
  logic [15:0] stall;
  logic [7:0]  gap;
  logic [1:0]  cand;
  logic        pick;
  logic        sel_valid;
  logic        sel_last;
  logic [7:0]  sel_data;
  logic [9:0]  sel_user;
  logic        accepting;
  // granted-source mux, round-robin pick and handshake decode from registered state
  always_comb begin
    cand = enable & {bus.s1_axis_tvalid, bus.s0_axis_tvalid};
    pick = (cand == 2'b11) ? ~last_grant : cand[1];
    sel_valid = grant ? bus.s1_axis_tvalid : bus.s0_axis_tvalid;
    sel_last = grant ? bus.s1_axis_tlast : bus.s0_axis_tlast;
    sel_data = grant ? bus.s1_axis_tdata : bus.s0_axis_tdata;
    sel_user = grant ? bus.s1_axis_tuser : bus.s0_axis_tuser;
    accepting = (state == ST_SEND) || (state == ST_DRAIN);
    bus.s0_axis_tready = accepting & ~grant;
    bus.s1_axis_tready = accepting & grant;
    end_state = (IFG != 8'd0) ? ST_GAP : ST_IDLE;
    busy = state != ST_IDLE;
  end
  // frame FSM: grant, forward with one-cycle latency, abort on long stall, drain, gap
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state <= ST_IDLE;
      grant <= 1'b0;
      last_grant <= 1'b1;
      stall <= 16'd0;
      gap <= 8'd0;
      frame_count0 <= 32'd0;
      frame_count1 <= 32'd0;
      abort_count <= 16'd0;
      bus.m_axis_tdata <= 8'd0;
      bus.m_axis_tuser <= 10'd0;
      bus.m_axis_tlast <= 1'b0;
      bus.m_axis_tvalid <= 1'b0;
      bus.m_axis_tid <= 1'b0;
    end else begin
      bus.m_axis_tvalid <= 1'b0;
      bus.m_axis_tlast <= 1'b0;
      case (state)
        ST_IDLE:
          if (|cand) begin
            grant <= pick;
            stall <= 16'd0;
            state <= ST_SEND;
          end
        ST_SEND:
          if (sel_valid) begin
            bus.m_axis_tdata <= sel_data;
            bus.m_axis_tuser <= sel_user;
            bus.m_axis_tlast <= sel_last;
            bus.m_axis_tvalid <= 1'b1;
            bus.m_axis_tid <= grant;
            stall <= 16'd0;
            if (sel_last) begin
              frame_count0 <= grant ? frame_count0 : frame_count0 + 32'd1;
              frame_count1 <= grant ? frame_count1 + 32'd1 : frame_count1;
              last_grant <= grant;
              gap <= 8'd0;
              state <= end_state;
            end
          end else if (stall == TIMEOUT - 16'd1) begin
            bus.m_axis_tdata <= 8'h00;
            bus.m_axis_tuser <= 10'h002;
            bus.m_axis_tlast <= 1'b1;
            bus.m_axis_tvalid <= 1'b1;
            bus.m_axis_tid <= grant;
            abort_count <= (&abort_count) ? abort_count : abort_count + 16'd1;
            state <= ST_ABORT;
          end else begin
            stall <= stall + 16'd1;
          end
        ST_ABORT:
          state <= ST_DRAIN;
        ST_DRAIN:
          if (sel_valid && sel_last) begin
            last_grant <= grant;
            gap <= 8'd0;
            state <= end_state;
          end
        ST_GAP: begin
          gap <= gap + 8'd1;
          state <= (gap == IFG - 8'd1) ? ST_IDLE : ST_GAP;
        end
        default:
          state <= ST_IDLE;
      endcase
    end
endmodule

// File: tb/tb_eth_frame_loop_arbiter.sv
// tb_eth_frame_loop_arbiter: randomized frames checked against a frame-level arbitration model
module tb_eth_frame_loop_arbiter;
  localparam int TO = 255;
  localparam int GAPN = 12;
  typedef struct { logic [7:0] d; logic [9:0] u; logic l; int dly; } beat_t;
  typedef struct { logic [19:0] v; int c; } obs_t;
  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic [1:0]  enable = 2'b11;
  logic        busy;
  logic [31:0] frame_count0;
  logic [31:0] frame_count1;
  logic [15:0] abort_count;
  beat_t       q0[$];
  beat_t       q1[$];
  beat_t       mq0[$];
  beat_t       mq1[$];
  obs_t        obs[$];
  logic [19:0] exp_q[$];
  int          acc0[$];
  int          cyc = 0;
  int          total = 0;
  int          bad = 0;
  int          rdy = 0;
  int          w0 = -1;
  int          w1 = -1;
  int          a0c = 0;
  bit          ac0;
  bit          ac1;
  int          m_last = 1;
  int          m_fc0 = 0;
  int          m_fc1 = 0;
  int          m_ab = 0;

  eth_frame_loop_arbiter_if bus ();

  eth_frame_loop_arbiter #(.TIMEOUT(16'(TO)), .IFG(8'(GAPN))) dut (
    .clk(clk),
    .rst_n(rst_n),
    .enable(enable),
    .bus(bus),
    .busy(busy),
    .frame_count0(frame_count0),
    .frame_count1(frame_count1),
    .abort_count(abort_count)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    bus.s0_axis_tvalid = 1'b0;
    bus.s1_axis_tvalid = 1'b0;
    bus.s0_axis_tdata = 8'd0;
    bus.s1_axis_tdata = 8'd0;
    bus.s0_axis_tuser = 10'd0;
    bus.s1_axis_tuser = 10'd0;
    bus.s0_axis_tlast = 1'b0;
    bus.s1_axis_tlast = 1'b0;
    forever begin
      @(negedge clk);
      if (ac0) begin
        acc0.push_back(a0c);
        void'(q0.pop_front());
        w0 = -1;
      end
      if (ac1) begin
        void'(q1.pop_front());
        w1 = -1;
      end
      bus.s0_axis_tvalid = 1'b0;
      if (q0.size() > 0) begin
        if (w0 < 0) w0 = q0[0].dly;
        if (w0 > 0) w0--;
        else begin
          bus.s0_axis_tdata = q0[0].d;
          bus.s0_axis_tuser = q0[0].u;
          bus.s0_axis_tlast = q0[0].l;
          bus.s0_axis_tvalid = 1'b1;
        end
      end
      bus.s1_axis_tvalid = 1'b0;
      if (q1.size() > 0) begin
        if (w1 < 0) w1 = q1[0].dly;
        if (w1 > 0) w1--;
        else begin
          bus.s1_axis_tdata = q1[0].d;
          bus.s1_axis_tuser = q1[0].u;
          bus.s1_axis_tlast = q1[0].l;
          bus.s1_axis_tvalid = 1'b1;
        end
      end
      ac0 = bus.s0_axis_tvalid && bus.s0_axis_tready;
      ac1 = bus.s1_axis_tvalid && bus.s1_axis_tready;
      a0c = cyc;
    end
  end

  initial begin
    obs_t o;
    forever begin
      @(negedge clk);
      if (bus.m_axis_tvalid === 1'b1) begin
        o.v = {bus.m_axis_tid, bus.m_axis_tlast, bus.m_axis_tuser, bus.m_axis_tdata};
        o.c = cyc;
        obs.push_back(o);
      end
      if ((bus.s0_axis_tready === 1'b1) || (bus.s1_axis_tready === 1'b1)) rdy++;
    end
  end

  task automatic chk(input string tag, input logic [63:0] o, input logic [63:0] e);
    total++;
    assert (o === e) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, o, e);
    end
  endtask

  task automatic mkframe(input int src, input int len, input int sat, input int slen, input int jit, input bit tomodel);
    beat_t b;
    for (int i = 0; i < len; i++) begin
      b.d = 8'($urandom);
      b.u = 10'($urandom);
      b.l = (i == len - 1);
      b.dly = (i == sat) ? slen : ((i > 0 && jit > 0) ? int'($urandom_range(jit, 0)) : 0);
      if (src == 0) begin
        q0.push_back(b);
        if (tomodel) mq0.push_back(b);
      end else begin
        q1.push_back(b);
        if (tomodel) mq1.push_back(b);
      end
    end
  endtask

  task automatic model(input logic [1:0] en);
    beat_t b;
    bit c0;
    bit c1;
    bit ab;
    int s;
    logic sb;
    forever begin
      c0 = en[0] && (mq0.size() > 0);
      c1 = en[1] && (mq1.size() > 0);
      if (!c0 && !c1) break;
      s = (c0 && c1) ? 1 - m_last : (c1 ? 1 : 0);
      sb = (s == 1);
      ab = 1'b0;
      do begin
        b = sb ? mq1.pop_front() : mq0.pop_front();
        if (!ab && b.dly >= TO) begin
          ab = 1'b1;
          exp_q.push_back({sb, 1'b1, 10'h002, 8'h00});
          m_ab = (m_ab < 65535) ? m_ab + 1 : m_ab;
        end
        if (!ab) exp_q.push_back({sb, b.l, b.u, b.d});
      end while (!b.l);
      m_last = s;
      if (!ab && sb) m_fc1++;
      if (!ab && !sb) m_fc0++;
    end
  endtask

  task automatic settle(input string tag);
    int n = 0;
    while ((q0.size() > 0 || q1.size() > 0 || busy !== 1'b0) && n < 20000) begin
      @(posedge clk);
      #2;
      n++;
    end
    repeat (3) @(posedge clk);
    #2;
    chk({tag, "_done"}, 64'(n < 20000), 64'd1);
  endtask

  task automatic wait_obs(input int k, input string tag);
    int n = 0;
    while (obs.size() < k && n < 5000) begin
      @(posedge clk);
      #2;
      n++;
    end
    chk(tag, 64'(n < 5000), 64'd1);
  endtask

  task automatic cmp(input string tag);
    chk({tag, "_len"}, 64'(obs.size()), 64'(exp_q.size()));
    for (int i = 0; i < obs.size() && i < exp_q.size(); i++)
      chk($sformatf("%s_b%0d", tag, i), 64'(obs[i].v), 64'(exp_q[i]));
    chk({tag, "_fc0"}, 64'(frame_count0), 64'(m_fc0));
    chk({tag, "_fc1"}, 64'(frame_count1), 64'(m_fc1));
    chk({tag, "_abort"}, 64'(abort_count), 64'(m_ab));
    obs.delete();
    exp_q.delete();
    acc0.delete();
  endtask

  task automatic do_reset(input string tag);
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    q0.delete();
    q1.delete();
    w0 = -1;
    w1 = -1;
    ac0 = 1'b0;
    ac1 = 1'b0;
    bus.s0_axis_tvalid = 1'b0;
    bus.s1_axis_tvalid = 1'b0;
    #1;
    chk({tag, "_m"}, 64'({bus.m_axis_tdata, bus.m_axis_tuser, bus.m_axis_tlast, bus.m_axis_tvalid, bus.m_axis_tid}), 64'd0);
    chk({tag, "_rdy_busy"}, 64'({bus.s0_axis_tready, bus.s1_axis_tready, busy}), 64'd0);
    chk({tag, "_fc0"}, 64'(frame_count0), 64'd0);
    chk({tag, "_fc1"}, 64'(frame_count1), 64'd0);
    chk({tag, "_abort"}, 64'(abort_count), 64'd0);
    repeat (2) @(negedge clk);
    #2;
    rst_n = 1'b1;
    obs.delete();
    exp_q.delete();
    mq0.delete();
    mq1.delete();
    acc0.delete();
    m_last = 1;
    m_fc0 = 0;
    m_fc1 = 0;
    m_ab = 0;
  endtask

  initial begin
    do_reset("rst0");
    mkframe(0, 64, -1, 0, 0, 1'b1);
    model(2'b11);
    settle("single");
    chk("lat_first", 64'(obs[0].c - acc0[0]), 64'd1);
    chk("lat_last", 64'(obs[63].c - acc0[63]), 64'd1);
    cmp("single");
    for (int k = 0; k < 2; k++) begin
      mkframe(0, 60, -1, 0, 0, 1'b1);
      mkframe(1, 60, -1, 0, 0, 1'b1);
    end
    mkframe(0, int'($urandom_range(40, 1)), -1, 0, 5, 1'b1);
    mkframe(1, int'($urandom_range(40, 1)), -1, 0, 5, 1'b1);
    model(2'b11);
    settle("alt");
    for (int i = 0; i + 1 < obs.size(); i++)
      if (obs[i].v[18]) chk($sformatf("gap%0d", i), 64'(obs[i + 1].c - obs[i].c), 64'(GAPN + 2));
    cmp("alt");
    mkframe(0, 30, 15, TO - 1, 0, 1'b1);
    mkframe(0, 25, 10, TO, 0, 1'b1);
    mkframe(1, 40, 20, 300, 0, 1'b1);
    model(2'b11);
    settle("abort");
    cmp("abort");
    enable = 2'b01;
    mkframe(0, 20, -1, 0, 0, 1'b1);
    mkframe(0, 10, -1, 0, 0, 1'b0);
    mkframe(1, 10, -1, 0, 0, 1'b0);
    model(2'b01);
    wait_obs(10, "en_b10");
    enable = 2'b00;
    wait_obs(20, "en_b20");
    rdy = 0;
    repeat (40) @(posedge clk);
    #2;
    chk("en_rdy", 64'(rdy), 64'd0);
    chk("en_busy", 64'(busy), 64'd0);
    cmp("en");
    do_reset("rst1");
    enable = 2'b11;
    mkframe(0, 64, -1, 0, 0, 1'b0);
    wait_obs(30, "mid_b30");
    do_reset("rst_mid");
    mkframe(1, 64, -1, 0, 3, 1'b1);
    mkframe(0, 20, -1, 0, 3, 1'b1);
    model(2'b11);
    settle("post");
    cmp("post");
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
